// File: rtl/mem_loader_pkg.sv
// Shared types for the boot-time program loader: state encoding and checksum width.
package mem_loader_pkg;

  localparam int unsigned LOADER_CSUM_WIDTH = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StVerify = 3'd2,
    StDrain  = 3'd3,
    StCheck  = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// 16-bit running sum of zero-extended bytes with synchronous clear and enable.
module loader_checksum
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [LOADER_CSUM_WIDTH-1:0] sum
);

  logic [LOADER_CSUM_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + LOADER_CSUM_WIDTH'(din);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: streams LENGTH bytes into memory at BASE_ADDR while holding the core in reset.
// Define MEM_LOADER_VERIFY_EN to add a readback pass that compares checksums before release.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 'h0100,
  parameter int unsigned LENGTH     = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  output logic                         mem_we,
  input  logic [DATA_WIDTH-1:0]        mem_dout,
  output logic                         hold_cpu,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [LOADER_CSUM_WIDTH-1:0] checksum
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  if (longint'(BASE_ADDR) + longint'(LENGTH) > (longint'(1) << ADDR_WIDTH)) begin : gen_bad_cfg
    $error("mem_loader: BASE_ADDR + LENGTH exceeds the address space");
  end

  loader_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clr, ld_en;
  logic s_ready_q, hold_q, busy_q, done_q;
  logic [LOADER_CSUM_WIDTH-1:0] ld_sum;

`ifdef MEM_LOADER_VERIFY_EN
  logic rb_en;
  logic error_q;
  logic [LOADER_CSUM_WIDTH-1:0] rb_sum;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    ld_en   = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
    rb_en   = 1'b0;
`endif
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          clr     = 1'b1;
          addr_d  = BASE;
          cnt_d   = '0;
          state_d = (LENGTH == 0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (s_valid) begin
          ld_en  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
`ifdef MEM_LOADER_VERIFY_EN
            state_d = StVerify;
            addr_d  = BASE;
            cnt_d   = '0;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      StVerify: begin
        // Read data lags the address by one cycle, so the first verify cycle has nothing to add.
        rb_en = (cnt_q != '0);
        if (cnt_q == LAST) begin
          state_d = StDrain;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      StDrain: begin
        rb_en   = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        state_d = (rb_sum == ld_sum) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= BASE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      s_ready_q  <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= (state_d == StLoad || state_d == StVerify) ? addr_d : '0;
      s_ready_q  <= (state_d == StLoad);
      busy_q     <= state_d inside {StLoad, StVerify, StDrain, StCheck};
      hold_q     <= state_d inside {StLoad, StVerify, StDrain, StCheck, StError};
      done_q     <= (state_d == StDone);
    end
  end

  loader_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_sum (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (ld_en),
    .din  (s_data),
    .sum  (ld_sum)
  );

`ifdef MEM_LOADER_VERIFY_EN
  loader_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_readback_sum (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (rb_en),
    .din  (mem_dout),
    .sum  (rb_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_d == StError);
    end
  end

  assign error = error_q;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign error = 1'b0;
`endif

  assign mem_we   = (state_q == StLoad) && s_valid;
  assign mem_din  = (state_q == StLoad) ? s_data : '0;
  assign mem_addr = mem_addr_q;
  assign s_ready  = s_ready_q;
  assign hold_cpu = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = ld_sum;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: table-driven loads, hand-written corner sequences and random loads.
module tb_mem_loader;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned LEN = 4;
  localparam logic [15:0] BASE = 16'h0100;
`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  // Edges from the final handshake edge until done/error is seen high.
  localparam int EXP_LAT = VERIFY ? LEN + 2 : 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, mem_we, hold_cpu, busy, done, error;
  logic [15:0] mem_addr, checksum;
  logic [7:0] mem_din, mem_dout;

  logic start0 = 1'b0;
  logic s_valid0 = 1'b0;
  logic [7:0] s_data0 = 8'h00;
  logic [7:0] mem_dout0 = 8'h00;
  logic s_ready0, mem_we0, hold0, busy0, done0, error0;
  logic [15:0] mem_addr0, checksum0;
  logic [7:0] mem_din0;

  always #5 clk = ~clk;

  mem_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0100), .LENGTH(LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .hold_cpu(hold_cpu), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  mem_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0100), .LENGTH(0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0), .s_valid(s_valid0), .s_data(s_data0),
    .s_ready(s_ready0), .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_we(mem_we0),
    .mem_dout(mem_dout0), .hold_cpu(hold0), .busy(busy0), .done(done0), .error(error0),
    .checksum(checksum0)
  );

  // Memory model: write on the edge, registered read; optional corruption of 0x0102 reads.
  logic [7:0] mem [0:65535];
  logic force_ff = 1'b0;
  int wr_count = 0;
  int rd_count = 0;
  int rd_bad = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      wr_count <= wr_count + 1;
    end
    mem_dout <= (force_ff && mem_addr == 16'h0102) ? 8'hFF : mem[mem_addr];
    if (busy && !s_ready && mem_addr != 16'h0000) begin
      rd_count <= rd_count + 1;
      if (mem_addr < BASE || mem_addr >= BASE + LEN) rd_bad <= rd_bad + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: memory gets the stream in order, checksum is the plain byte sum mod 2^16.
  function automatic logic [15:0] model_sum(input logic [3:0][7:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(b[i]);
    return s[15:0];
  endfunction

  // gap_mode: 0 back-to-back, 1 pattern 1,0,0,1..., 2 random gaps. Inputs change #1 after posedge.
  task automatic do_load(input logic [3:0][7:0] b, input logic [15:0] exp_csum,
                         input int gap_mode, input bit mid_start, input bit exp_err);
    int n;
    int gaps;
    int wr0;
    int rd0;
    int rdb0;
    wr0  = wr_count;
    rd0  = rd_count;
    rdb0 = rd_bad;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gaps = (gap_mode == 1 && i > 0) ? 2 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom());
        @(negedge clk);
        check("gap_we", mem_we, 1'b0);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = b[i];
      start   = mid_start && (i == 2);
      @(negedge clk);
      check("hs_we", mem_we, 1'b1);
      check("hs_addr", mem_addr, BASE + 16'(i));
      check("hs_din", mem_din, b[i]);
      check("hs_hold", {s_ready, hold_cpu}, 2'b11);
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    n = 0;
    while (!(done || error) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, EXP_LAT);
    check("done_err", {done, error}, {~exp_err, exp_err});
    check("hold_end", hold_cpu, exp_err);
    check("busy_end", busy, 1'b0);
    check("csum", checksum, exp_csum);
    check("wr_count", wr_count - wr0, 4);
    for (int i = 0; i < 4; i++) check("mem", mem[BASE + 16'(i)], b[i]);
    if (VERIFY) begin
      check("rd_count", rd_count - rd0, 4);
      check("rd_range", rd_bad - rdb0, 0);
    end
  endtask

  typedef struct {
    logic [3:0][7:0] data;
    logic [15:0]     csum;
    int              gap_mode;
    bit              mid_start;
  } vec_t;

  vec_t tbl [6];
  int wr_snap;
  logic [3:0][7:0] rb;
  bit fe;

  initial begin
    tbl[0] = '{data: 32'h008D05A9, csum: 16'h013B, gap_mode: 0, mid_start: 1'b0};
    tbl[1] = '{data: 32'h008D05A9, csum: 16'h013B, gap_mode: 1, mid_start: 1'b0};
    tbl[2] = '{data: 32'hFFFFFFFF, csum: 16'h03FC, gap_mode: 0, mid_start: 1'b1};
    tbl[3] = '{data: 32'h04030201, csum: 16'h000A, gap_mode: 2, mid_start: 1'b0};
    tbl[4] = '{data: 32'hEF107F80, csum: 16'h01FE, gap_mode: 0, mid_start: 1'b0};
    tbl[5] = '{data: 32'h00000000, csum: 16'h0000, gap_mode: 1, mid_start: 1'b1};

    @(negedge clk);
    check("rst_flags", {s_ready, mem_we, hold_cpu, busy, done, error}, 6'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_din", mem_din, 8'h00);
    check("rst_csum", checksum, 16'h0000);
    check("rst_len0", {s_ready0, mem_we0, hold0, busy0, done0, error0, mem_din0, checksum0}, 0);
    check("rst_len0_addr", mem_addr0, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // LENGTH=0 instance finishes on the edge that samples start.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("len0_done", {done0, hold0, busy0, s_ready0, error0}, 5'b10000);
    check("len0_mem", {mem_we0, mem_addr0, checksum0}, 0);

    for (int t = 0; t < 6; t++) do_load(tbl[t].data, tbl[t].csum, tbl[t].gap_mode,
                                        tbl[t].mid_start, 1'b0);

    // Reset after two of four bytes: immediate quiet outputs, no further writes.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h11 * 8'(i + 1);
      @(posedge clk); #1;
    end
    s_data  = 8'h55;
    wr_snap = wr_count;
    reset   = 1'b1;
    #1;
    check("abort_flags", {s_ready, mem_we, hold_cpu, busy, done, error}, 6'b0);
    check("abort_addr", mem_addr, 16'h0000);
    check("abort_csum", checksum, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_nowrite", wr_count - wr_snap, 0);
    reset   = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    do_load(32'h44332211, 16'h00AA, 0, 1'b0, 1'b0);

    // Corrupted readback of 0x0102 must be flagged when verify is built in.
    if (VERIFY) begin
      force_ff = 1'b1;
      do_load(32'h008D05A9, 16'h013B, 0, 1'b0, 1'b1);
      force_ff = 1'b0;
    end

    for (int r = 0; r < 20; r++) begin
      rb = $urandom();
      fe = VERIFY && ($urandom_range(0, 1) == 1);
      force_ff = fe;
      do_load(rb, model_sum(rb), 2, ($urandom_range(0, 3) == 0), fe && (rb[2] != 8'hFF));
      force_ff = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
